trace_capture: RTL
==================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter: XLEN, 32, width of PC and write-back data fields.
REQ-002 Parameter: DEPTH, 16, trace entries; power of two, 2..1024.
REQ-003 Parameter: POST_TRIG, 4, committed instructions captured after trigger match (0..DEPTH-1).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 clr  in  1  synchronous clear of buffer, flags and FSM.
REQ-007 cap_en  in  1  arm/continue capture; deassert = manual stop.
REQ-008 mode  in  2  00 wrap, 01 stop-on-full, 10 trigger, 11 treated as 00.
REQ-009 trig_pc  in  XLEN  trigger PC compared in mode 10.
REQ-010 commit  in  1  one instruction retires this cycle.
REQ-011 pc  in  XLEN  PC of retiring instruction.
REQ-012 wb_en / wb_addr / wb_data  in  1 / 5 / XLEN  register write-back of retiring instruction.
REQ-013 rd_valid  out  1  oldest entry available.
REQ-014 rd_ready  in  1  consumer accepts entry.
REQ-015 rd_pc / rd_wben / rd_wbaddr / rd_wbdata  out  XLEN / 1 / 5 / XLEN  oldest entry fields.
REQ-016 count  out  clog2(DEPTH)+1  stored entries.
REQ-017 state  out  2  00 IDLE, 01 CAPT, 10 POST, 11 DONE.
REQ-018 overflow / triggered  out  1 / 1  sticky flags.

Function
REQ-019 Record = {pc, wb_en, wb_addr, wb_data}; written only when commit=1 in CAPT or POST; wb_addr/wb_data stored as 0 when wb_en=0.
REQ-020 Circular buffer: write pointer, read pointer, count; pointers wrap modulo DEPTH.
REQ-021 Priority per cycle: RST > clr > cap_en=0 stop > trigger/full evaluation > normal write.
REQ-022 clr=1: state IDLE, pointers 0, count 0, overflow 0, triggered 0, next cycle.
REQ-023 IDLE: cap_en=1 -> CAPT next cycle, pointers/count/flags cleared on entry; commit in the IDLE cycle not recorded.
REQ-024 CAPT/POST with cap_en=0 -> DONE; that cycle's commit not recorded.
REQ-025 CAPT mode 00/10, count==DEPTH and commit: overwrite oldest, advance read pointer, count stays DEPTH, overflow=1.
REQ-026 CAPT mode 01: write that brings count to DEPTH -> DONE next cycle; overflow never set.
REQ-027 CAPT mode 10, commit with pc==trig_pc: record written, triggered=1, post counter loaded POST_TRIG; -> POST, or -> DONE if POST_TRIG=0.
REQ-028 POST: each commit written (wrap rules of REQ-025), counter decrements; write taking counter to 0 -> DONE; further trig_pc matches ignored.
REQ-029 Mode sampled every cycle; changing mode mid-capture takes effect next cycle; a mode-01 full condition reached under 00 does not retroactively stop.
REQ-030 DONE: holds until clr; cap_en ignored.
REQ-031 rd_valid = (state==DONE) && (count!=0); rd_* driven combinationally from read pointer; rd_* = 0 when rd_valid=0.
REQ-032 Pop on rising edge with rd_valid && rd_ready: read pointer +1, count -1; rd_* stable while rd_valid=1 and rd_ready=0.
REQ-033 Entries read out oldest-first; after wrap, oldest = first record not overwritten.

Reset
REQ-034 RST=0 immediately (asynchronously): state IDLE, pointers 0, count 0, overflow 0, triggered 0, rd_valid 0, all rd_* 0; buffer contents undefined and unobservable.
REQ-035 RST asserted mid-capture or mid-readout aborts without completing the in-flight write or pop.
REQ-036 Deassertion synchronous to CLK in system; block takes no action until the first edge after RST=1.

Verification
REQ-037 Mode 01, DEPTH=16, 20 commits pc=0x0,0x4,...: DONE after 16th, count=16, readout pc 0x0..0x3C in order, overflow=0.
REQ-038 Mode 00, 20 commits then cap_en=0: DONE, count=16, overflow=1, first rd_pc=0x10, last 0x4C.
REQ-039 Mode 10, trig_pc=0x20, POST_TRIG=4, commits pc 0x0 step 4: triggered=1 at 0x20, DONE after pc=0x30, last entry 0x30, count=13.
REQ-040 DONE with count=3, rd_ready low 5 cycles then high: rd_* constant while stalled, three pops, rd_valid=0, count=0.
REQ-041 RST low during CAPT with count=7: state/count/flags 0 without a clock edge; clr during POST -> IDLE next cycle.

Source files
------------

// File: rtl/trace_capture.sv
// Instruction trace capture. A circular record buffer with wrap, stop-on-full and
// PC-trigger modes. After capture completes, the buffer is drained oldest-first.
//
// state | meaning
// IDLE  | waiting for cap_en
// CAPT  | recording committed instructions
// POST  | recording the post-trigger window
// DONE  | capture frozen; buffer drained through rd_*
module trace_capture #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    cap_en,
  input  logic [1:0]              mode,
  input  logic [XLEN-1:0]         trig_pc,
  input  logic                    commit,
  input  logic [XLEN-1:0]         pc,
  input  logic                    wb_en,
  input  logic [4:0]              wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [XLEN-1:0]         rd_pc,
  output logic                    rd_wben,
  output logic [4:0]              rd_wbaddr,
  output logic [XLEN-1:0]         rd_wbdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic [1:0]              state,
  output logic                    overflow,
  output logic                    triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * XLEN + 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CAPT = 2'b01,
    S_POST = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t        st;
  logic [AW-1:0] wr_ptr, rd_ptr, post_cnt;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rec_w, rec_r;
  logic [1:0]    mode_eff;
  logic          full, last_slot, capturing, stop_full, do_wr, trig_hit, do_pop;

  assign state     = st;
  assign mode_eff  = (mode == 2'b11) ? 2'b00 : mode;
  assign full      = (count == CW'(DEPTH));
  assign last_slot = (count == CW'(DEPTH - 1));
  assign capturing = (st == S_CAPT) || (st == S_POST);
  // stop-on-full that finds the buffer already full (filled under wrap mode) ends without writing
  assign stop_full = (st == S_CAPT) && (mode_eff == 2'b01) && full;
  assign do_wr     = !clr && capturing && cap_en && commit && !stop_full;
  assign trig_hit  = (st == S_CAPT) && (mode_eff == 2'b10) && (pc == trig_pc);
  assign rd_valid  = (st == S_DONE) && (count != '0);
  assign do_pop    = !clr && rd_valid && rd_ready;

  assign rec_w = {pc, wb_en, (wb_en ? wb_addr : 5'd0), (wb_en ? wb_data : {XLEN{1'b0}})};

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rec_w;
  end

  assign rec_r     = mem[rd_ptr];
  assign rd_pc     = rd_valid ? rec_r[RW-1 -: XLEN] : '0;
  assign rd_wben   = rd_valid & rec_r[XLEN+5];
  assign rd_wbaddr = rd_valid ? rec_r[XLEN+4 -: 5] : 5'd0;
  assign rd_wbdata = rd_valid ? rec_r[XLEN-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else if (clr) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) begin
          rd_ptr   <= rd_ptr + AW'(1);
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
      case (st)
        S_IDLE: begin
          if (cap_en) begin
            st        <= S_CAPT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
          end
        end
        S_CAPT: begin
          if (!cap_en || (commit && stop_full)) begin
            st <= S_DONE;
          end else if (commit) begin
            if (mode_eff == 2'b01 && last_slot) begin
              st <= S_DONE;
            end else if (trig_hit) begin
              triggered <= 1'b1;
              post_cnt  <= AW'(POST_TRIG);
              st        <= (POST_TRIG == 0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (!cap_en) begin
            st <= S_DONE;
          end else if (commit) begin
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) st <= S_DONE;
          end
        end
        S_DONE: ;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
